// File: rtl/odeeen_pkg.sv
// odeeen_pkg: loader command bytes and state encodings.
// Shared by uart_rx and uart_loader.
package odeeen_pkg;

  localparam logic [7:0] CMD_WRITE  = 8'hA5;
  localparam logic [7:0] CMD_FINISH = 8'h5A;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_SUM,
    ST_WRITE,
    ST_DONE
  } ld_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

endpackage

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver, two-flop synchroniser, mid-bit sampling.
// Emits a one-cycle byte_valid or frame_err per received frame.
module uart_rx
  import odeeen_pkg::*;
#(
  parameter int DIV = 217
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int CW = $clog2(DIV + 1);
  localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(DIV - 1);

  rx_state_e     st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;
  logic          sync1_q, sync2_q, prev_q;

  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    unique case (st_q)
      RX_IDLE: begin
        if (prev_q && !sync2_q) begin
          st_d  = RX_START;
          cnt_d = HALF;
        end
      end
      RX_START: begin
        if (cnt_q == '0) begin
          // glitch shorter than half a bit is not a start bit
          if (sync2_q) begin
            st_d = RX_IDLE;
          end else begin
            st_d  = RX_DATA;
            cnt_d = FULL;
            bit_d = '0;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == '0) begin
          shift_d = {sync2_q, shift_q[7:1]};
          cnt_d   = FULL;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) st_d = RX_STOP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RX_STOP: begin
        if (cnt_q == '0) begin
          st_d = RX_IDLE;
          if (sync2_q) begin
            valid_d = 1'b1;
            data_d  = shift_q;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: st_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q    <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      sync1_q <= rx;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign byte_valid = valid_q;
  assign byte_data  = data_q;
  assign frame_err  = err_q;

endmodule

// File: rtl/uart_loader.sv
// uart_loader: serial boot loader writing words onto a valid/ready bus.
// Define UART_LOADER_CHECKSUM_EN to require an XOR checksum byte per frame.
module uart_loader
  import odeeen_pkg::*;
#(
  parameter int CLK_HZ = 25000000,
  parameter int BAUD   = 115200
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rx,
  output logic        mem_valid,
  output logic        mem_instr,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  output logic        cpu_hold,
  output logic        error
);

  localparam int DIV = CLK_HZ / BAUD;

  logic       byte_valid, frame_err;
  logic [7:0] byte_data;

  uart_rx #(.DIV(DIV)) u_rx (
    .clk        (clk),
    .reset_n    (reset_n),
    .rx         (rx),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .frame_err  (frame_err)
  );

  ld_state_e   st_q, st_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        valid_q, valid_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        hold_q, hold_d;
  logic        err_q, err_d;
  logic        buf_vld_q, buf_vld_d;
  logic [7:0]  buf_q, buf_d;
  logic        take, in_vld;
  logic [7:0]  in_b;
  logic        rdata_unused;
`ifdef UART_LOADER_CHECKSUM_EN
  logic [7:0]  sum_q, sum_d;
`endif

  assign rdata_unused = ^mem_rdata;

  always_comb begin
    st_d      = st_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    valid_d   = valid_q;
    wstrb_d   = wstrb_q;
    hold_d    = hold_q;
    err_d     = err_q | frame_err;
    buf_vld_d = buf_vld_q;
    buf_d     = buf_q;
    in_vld    = 1'b0;
    in_b      = byte_data;
`ifdef UART_LOADER_CHECKSUM_EN
    sum_d     = sum_q;
`endif
    take = (st_q != ST_WRITE) && (st_q != ST_DONE);
    if (take && buf_vld_q) begin
      in_vld    = 1'b1;
      in_b      = buf_q;
      buf_vld_d = 1'b0;
    end else if (take && byte_valid) begin
      in_vld = 1'b1;
    end
    // park a byte that cannot be consumed this cycle
    if (byte_valid && st_q != ST_DONE && !(take && !buf_vld_q)) begin
      if (buf_vld_d) begin
        err_d = 1'b1;
      end else begin
        buf_vld_d = 1'b1;
        buf_d     = byte_data;
      end
    end
    unique case (st_q)
      ST_IDLE: begin
        if (in_vld) begin
          unique case (1'b1)
            (in_b == CMD_WRITE): begin
              st_d  = ST_ADDR;
              cnt_d = 2'd0;
`ifdef UART_LOADER_CHECKSUM_EN
              sum_d = 8'h00;
`endif
            end
            (in_b == CMD_FINISH): begin
              st_d   = ST_DONE;
              hold_d = 1'b0;
            end
            default: ;
          endcase
        end
      end
      ST_ADDR: begin
        if (in_vld) begin
          addr_d = {in_b, addr_q[31:8]};
          cnt_d  = cnt_q + 2'd1;
`ifdef UART_LOADER_CHECKSUM_EN
          sum_d  = sum_q ^ in_b;
`endif
          if (cnt_q == 2'd3) st_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (in_vld) begin
          wdata_d = {in_b, wdata_q[31:8]};
          cnt_d   = cnt_q + 2'd1;
`ifdef UART_LOADER_CHECKSUM_EN
          sum_d   = sum_q ^ in_b;
          if (cnt_q == 2'd3) st_d = ST_SUM;
`else
          if (cnt_q == 2'd3) begin
            st_d    = ST_WRITE;
            valid_d = 1'b1;
            wstrb_d = 4'b1111;
          end
`endif
        end
      end
      ST_SUM: begin
`ifdef UART_LOADER_CHECKSUM_EN
        if (in_vld) begin
          if (in_b == sum_q) begin
            st_d    = ST_WRITE;
            valid_d = 1'b1;
            wstrb_d = 4'b1111;
          end else begin
            st_d  = ST_IDLE;
            err_d = 1'b1;
          end
        end
`else
        st_d = ST_IDLE;
`endif
      end
      ST_WRITE: begin
        if (valid_q && mem_ready) begin
          st_d    = ST_IDLE;
          valid_d = 1'b0;
          wstrb_d = 4'b0000;
        end
      end
      ST_DONE: ;
      default: st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q      <= ST_IDLE;
      cnt_q     <= 2'd0;
      addr_q    <= '0;
      wdata_q   <= '0;
      valid_q   <= 1'b0;
      wstrb_q   <= 4'b0000;
      hold_q    <= 1'b1;
      err_q     <= 1'b0;
      buf_vld_q <= 1'b0;
      buf_q     <= '0;
`ifdef UART_LOADER_CHECKSUM_EN
      sum_q     <= '0;
`endif
    end else begin
      st_q      <= st_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      valid_q   <= valid_d;
      wstrb_q   <= wstrb_d;
      hold_q    <= hold_d;
      err_q     <= err_d;
      buf_vld_q <= buf_vld_d;
      buf_q     <= buf_d;
`ifdef UART_LOADER_CHECKSUM_EN
      sum_q     <= sum_d;
`endif
    end
  end

  assign mem_valid = valid_q;
  assign mem_instr = 1'b0;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wstrb = wstrb_q;
  assign cpu_hold  = hold_q;
  assign error     = err_q;

endmodule
